axi_read_slave_fsm: RTL and testbench

- AXI4 read-channel responder (AR + R); the read-direction counterpart of the write-channel master/slave pair.
- Accepts one AR burst at a time and walks the burst addresses (FIXED/INCR/WRAP).
- Fetches each beat from a 1-cycle-latency backend memory port and returns it on R with RRESP/RLAST.
- Backend stall is via `read_ready`.

---
 rtl/axi_pkg.sv | 20 ++
 rtl/axi_burst_addr_gen.sv | 30 +++
 rtl/axi_read_slave_fsm.sv | 180 ++++++++++++++++++
 tb/tb_axi_read_slave_fsm.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and read-channel FSM state type.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LOAD,
        DATA
    } rd_state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI4 burst next-address calculator (FIXED/INCR/WRAP).
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [AW-1:0] addr,
    input  logic [2:0]    size,
    input  logic [7:0]    len,
    input  logic [1:0]    burst,
    output logic [AW-1:0] next_addr
);

    logic [AW-1:0] step;
    logic [AW-1:0] wrap_bytes;

    always_comb begin
        step       = AW'(1) << size;
        wrap_bytes = step * (AW'(len) + AW'(1));
        next_addr  = addr;
        unique case (burst)
            BURST_INCR: next_addr = (addr & ~(step - AW'(1))) + step;
            // wrap_bytes is a power of two only for legal WRAP lengths
            BURST_WRAP: next_addr = (addr & ~(wrap_bytes - AW'(1)))
                                  | ((addr + step) & (wrap_bytes - AW'(1)));
            default:    next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_read_slave_fsm.sv
// AXI4 read responder: one AR burst at a time, 1-cycle backend, R beats.
// Optional address window decode via AXI_RD_RANGE_CHECK_EN.
module axi_read_slave_fsm
    import axi_pkg::*;
#(
    parameter int          AW        = 32,
    parameter int          DW        = 64,
    parameter int unsigned ADDR_BASE = 0,
    parameter int unsigned ADDR_SPAN = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] s_axi_araddr,
    input  logic [7:0]    s_axi_arlen,
    input  logic [2:0]    s_axi_arsize,
    input  logic [1:0]    s_axi_arburst,
    input  logic          s_axi_arvalid,
    output logic          s_axi_arready,
    output logic [DW-1:0] s_axi_rdata,
    output logic [1:0]    s_axi_rresp,
    output logic          s_axi_rlast,
    output logic          s_axi_rvalid,
    input  logic          s_axi_rready,
    input  logic          read_ready,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_rd_data,
    output logic          busy
);

    localparam logic [2:0] MAX_SIZE = 3'($clog2(DW / 8));

    rd_state_e     state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    len_q, len_d;
    logic [2:0]    size_q, size_d;
    logic [1:0]    burst_q, burst_d;
    logic [7:0]    beat_q, beat_d;
    logic          slverr_q, slverr_d;
    logic          arready_q, arready_d;
    logic          rvalid_q, rvalid_d;
    logic          rlast_q, rlast_d;
    logic [1:0]    rresp_q, rresp_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic [AW-1:0] next_addr;
    logic [AW-1:0] phys_addr;
    logic          decerr;
    logic          beat_err;
    logic [1:0]    beat_resp;
    logic          ar_err;

    axi_burst_addr_gen #(
        .AW (AW)
    ) u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

`ifdef AXI_RD_RANGE_CHECK_EN
    assign phys_addr = addr_q - AW'(ADDR_BASE);
    assign decerr    = !((addr_q >= AW'(ADDR_BASE))
                      && ({1'b0, phys_addr} < (AW+1)'(ADDR_SPAN)));
`else
    logic unused_range;
    assign unused_range = ^{ADDR_BASE, ADDR_SPAN};
    assign phys_addr    = addr_q;
    assign decerr       = 1'b0;
`endif

    assign ar_err = (s_axi_arsize > MAX_SIZE)
                 || (s_axi_arburst == 2'b11)
                 || ((s_axi_arburst == BURST_WRAP)
                     && !(s_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

    assign beat_err  = slverr_q || decerr;
    assign beat_resp = slverr_q ? RESP_SLVERR :
                       decerr   ? RESP_DECERR : RESP_OKAY;

    assign mem_rd_en     = (state_q == FETCH) && read_ready && !beat_err;
    assign mem_rd_addr   = mem_rd_en ? phys_addr : '0;
    assign busy          = (state_q != IDLE);
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        slverr_d  = slverr_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        unique case (state_q)
            IDLE: begin
                arready_d = 1'b1;
                if (s_axi_arvalid && arready_q) begin
                    addr_d    = s_axi_araddr;
                    len_d     = s_axi_arlen;
                    size_d    = s_axi_arsize;
                    burst_d   = s_axi_arburst;
                    beat_d    = 8'd0;
                    slverr_d  = ar_err;
                    arready_d = 1'b0;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                // error beats never touch the backend, so no stall
                if (read_ready || beat_err) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                rdata_d  = beat_err ? '0 : mem_rd_data;
                rresp_d  = beat_resp;
                rlast_d  = (beat_q == len_q);
                rvalid_d = 1'b1;
                state_d  = DATA;
            end
            DATA: begin
                if (s_axi_rready) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    if (rlast_q) begin
                        arready_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        addr_d  = next_addr;
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            beat_q    <= '0;
            slverr_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
            slverr_q  <= slverr_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_axi_read_slave_fsm.sv
// Bench for axi_read_slave_fsm: directed table, corner sequences, random bursts.
module tb_axi_read_slave_fsm;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam logic [31:0] BASE = 32'h1000;
    localparam logic [31:0] SPAN = 32'h100;
`ifdef AXI_RD_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif
    localparam logic [31:0] OFS = RANGE_EN ? BASE : 32'h0;

    typedef struct packed {
        logic [63:0] d;
        logic [1:0]  r;
        logic        l;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [1:0]  resp;
        logic [31:0] ea [4];
    } tv_t;

    logic          clk;
    logic          rst;
    logic [AW-1:0] s_axi_araddr;
    logic [7:0]    s_axi_arlen;
    logic [2:0]    s_axi_arsize;
    logic [1:0]    s_axi_arburst;
    logic          s_axi_arvalid;
    logic          s_axi_arready;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rlast;
    logic          s_axi_rvalid;
    logic          s_axi_rready;
    logic          read_ready;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int first_rd;
    int first_rv;
    int hs_cyc;
    bit rnd_mode = 1'b0;

    logic [31:0] got_rd[$];
    logic [31:0] exp_rd[$];
    beat_t       got_b[$];
    beat_t       exp_b[$];

    axi_read_slave_fsm #(
        .AW        (AW),
        .DW        (DW),
        .ADDR_BASE (BASE),
        .ADDR_SPAN (SPAN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .read_ready    (read_ready),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] memf(input logic [31:0] a);
        return {a ^ 32'hC3A5_5A3C, ~a};
    endfunction

    // backend: data valid only in the cycle after the strobe
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= memf(mem_rd_addr);
        else           mem_rd_data <= 64'hDEAD_0000_BAD0_0000;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd_en) begin
                got_rd.push_back(mem_rd_addr);
                if (first_rd < 0) first_rd = cyc;
            end
            if (s_axi_rvalid && first_rv < 0) first_rv = cyc;
            if (s_axi_rvalid && s_axi_rready)
                got_b.push_back({s_axi_rdata, s_axi_rresp, s_axi_rlast});
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_mode) begin
                s_axi_rready = ($urandom % 4) != 0;
                read_ready   = ($urandom % 3) != 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic issue_ar(input logic [31:0] a, input logic [7:0] l,
                            input logic [2:0] sz, input logic [1:0] b);
        int n;
        got_rd.delete();
        got_b.delete();
        first_rd = -1;
        first_rv = -1;
        @(posedge clk);
        #1;
        s_axi_araddr  = a;
        s_axi_arlen   = l;
        s_axi_arsize  = sz;
        s_axi_arburst = b;
        s_axi_arvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_axi_arready && n < 50);
        chk("ar_wait", n, 1);
        @(posedge clk);
        #1;
        hs_cyc = cyc;
        s_axi_arvalid = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int k = 0;
        while (got_b.size() < n && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("beat_count", got_b.size(), n);
    endtask

    task automatic wait_rv();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!s_axi_rvalid && k < 50);
        chk("rvalid_seen", s_axi_rvalid, 1'b1);
    endtask

    // reference: beat addresses from burst arithmetic, not from next-address recurrence
    task automatic model(input logic [31:0] a0, input logic [7:0] l,
                         input logic [2:0] sz, input logic [1:0] b);
        longint unsigned s, wb, a;
        bit err, dec;
        logic [31:0] ai, ph;
        logic [1:0] rs;
        exp_rd.delete();
        exp_b.delete();
        s  = 64'd1 << sz;
        wb = s * (l + 1);
        err = (sz > 3) || (b == 2'b11)
           || (b == 2'b10 && !(l == 1 || l == 3 || l == 7 || l == 15));
        for (int i = 0; i <= int'(l); i++) begin
            case (b)
                2'b01:   a = (i == 0) ? a0 : (a0 / s) * s + i * s;
                2'b10:   a = (a0 / wb) * wb + (a0 + i * s) % wb;
                default: a = a0;
            endcase
            ai  = 32'(a);
            dec = RANGE_EN && !(ai >= BASE && (ai - BASE) < SPAN);
            ph  = RANGE_EN ? ai - BASE : ai;
            rs  = err ? 2'b10 : (dec ? 2'b11 : 2'b00);
            if (rs == 2'b00) exp_rd.push_back(ph);
            exp_b.push_back({(rs == 2'b00) ? memf(ph) : 64'd0, rs,
                             i == int'(l)});
        end
    endtask

    task automatic cmp_model();
        chk("rd_count", got_rd.size(), exp_rd.size());
        for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++)
            chk("rd_addr", got_rd[i], exp_rd[i]);
        for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) begin
            chk("beat_data", got_b[i].d, exp_b[i].d);
            chk("beat_resp", got_b[i].r, exp_b[i].r);
            chk("beat_last", got_b[i].l, exp_b[i].l);
        end
    endtask

    initial begin
        tv_t tab[9];
        logic [31:0] ra;
        logic [7:0]  rl;
        logic [2:0]  rsz;
        logic [1:0]  rb;

        tab[0] = '{32'h100, 8'd3, 3'd3, 2'b01, 2'b00,
                   '{32'h100, 32'h108, 32'h110, 32'h118}};
        tab[1] = '{32'h38, 8'd3, 3'd3, 2'b10, 2'b00,
                   '{32'h38, 32'h20, 32'h28, 32'h30}};
        tab[2] = '{32'h40, 8'd2, 3'd3, 2'b00, 2'b00,
                   '{32'h40, 32'h40, 32'h40, 32'h0}};
        tab[3] = '{32'h106, 8'd2, 3'd2, 2'b01, 2'b00,
                   '{32'h106, 32'h108, 32'h10C, 32'h0}};
        tab[4] = '{32'h14, 8'd1, 3'd2, 2'b10, 2'b00,
                   '{32'h14, 32'h10, 32'h0, 32'h0}};
        tab[5] = '{32'h80, 8'd1, 3'd4, 2'b01, 2'b10,
                   '{32'h0, 32'h0, 32'h0, 32'h0}};
        tab[6] = '{32'h80, 8'd2, 3'd3, 2'b11, 2'b10,
                   '{32'h0, 32'h0, 32'h0, 32'h0}};
        tab[7] = '{32'h80, 8'd2, 3'd3, 2'b10, 2'b10,
                   '{32'h0, 32'h0, 32'h0, 32'h0}};
        tab[8] = '{32'h7, 8'd0, 3'd0, 2'b01, 2'b00,
                   '{32'h7, 32'h0, 32'h0, 32'h0}};

        rst = 1'b1;
        s_axi_araddr = '0;
        s_axi_arlen = '0;
        s_axi_arsize = '0;
        s_axi_arburst = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b1;
        read_ready = 1'b1;
        first_rd = -1;
        first_rv = -1;
        hs_cyc = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", s_axi_arready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rvalid", s_axi_rvalid, 1'b0);
        chk("rst_mem_rd_en", mem_rd_en, 1'b0);
        chk("rst_rdata", s_axi_rdata, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_arready", s_axi_arready, 1'b1);

`ifndef AXI_RD_RANGE_CHECK_EN
        for (int t = 0; t < 9; t++) begin
            issue_ar(tab[t].addr, tab[t].len, tab[t].size, tab[t].burst);
            wait_beats(int'(tab[t].len) + 1);
            chk("rv_latency", first_rv - hs_cyc, 2);
            if (tab[t].resp == 2'b00) begin
                chk("rd_latency", first_rd - hs_cyc, 0);
                chk("tab_rd_count", got_rd.size(), int'(tab[t].len) + 1);
            end else begin
                chk("tab_err_no_rd", got_rd.size(), 0);
            end
            for (int i = 0; i < got_b.size() && i < 4; i++) begin
                if (tab[t].resp == 2'b00 && i < got_rd.size())
                    chk("tab_rd_addr", got_rd[i], tab[t].ea[i]);
                chk("tab_rresp", got_b[i].r, tab[t].resp);
                chk("tab_rdata", got_b[i].d,
                    (tab[t].resp == 2'b00) ? memf(tab[t].ea[i]) : 64'd0);
                chk("tab_rlast", got_b[i].l, i == int'(tab[t].len));
            end
        end
`else
        issue_ar(32'h10F8, 8'd1, 3'd3, 2'b01);
        wait_beats(2);
        chk("rng_rd_count", got_rd.size(), 1);
        if (got_rd.size() > 0) chk("rng_rd_addr", got_rd[0], 32'hF8);
        if (got_b.size() == 2) begin
            chk("rng_b0_resp", got_b[0].r, 2'b00);
            chk("rng_b0_data", got_b[0].d, memf(32'hF8));
            chk("rng_b0_last", got_b[0].l, 1'b0);
            chk("rng_b1_resp", got_b[1].r, 2'b11);
            chk("rng_b1_data", got_b[1].d, 64'd0);
            chk("rng_b1_last", got_b[1].l, 1'b1);
        end
`endif

        // FIXED burst with the master stalling beat 2
        s_axi_rready = 1'b0;
        issue_ar(OFS + 32'h40, 8'd2, 3'd3, 2'b00);
        wait_rv();
        @(posedge clk);
        #1 s_axi_rready = 1'b1;
        @(posedge clk);
        #1 s_axi_rready = 1'b0;
        wait_rv();
        repeat (5) begin
            @(negedge clk);
            chk("hold_rvalid", s_axi_rvalid, 1'b1);
            chk("hold_rdata", s_axi_rdata, memf(32'h40));
            chk("hold_rlast", s_axi_rlast, 1'b0);
            chk("hold_rresp", s_axi_rresp, 2'b00);
            chk("hold_no_rd", mem_rd_en, 1'b0);
        end
        @(posedge clk);
        #1 s_axi_rready = 1'b1;
        wait_beats(3);
        model(OFS + 32'h40, 8'd2, 3'd3, 2'b00);
        cmp_model();

        // backend stall then reset mid-burst
        read_ready = 1'b0;
        issue_ar(OFS + 32'h20, 8'd3, 3'd3, 2'b01);
        repeat (4) begin
            @(negedge clk);
            chk("stall_no_rd", mem_rd_en, 1'b0);
            chk("stall_busy", busy, 1'b1);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 read_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_arready", s_axi_arready, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rvalid", s_axi_rvalid, 1'b0);
        chk("mid_rst_rlast", s_axi_rlast, 1'b0);
        chk("mid_rst_rresp", s_axi_rresp, 2'b00);
        chk("mid_rst_rdata", s_axi_rdata, 64'd0);
        chk("mid_rst_mem_rd_en", mem_rd_en, 1'b0);
        chk("mid_rst_mem_rd_addr", mem_rd_addr, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_arready", s_axi_arready, 1'b1);
        chk("post_rst_no_beats", got_b.size(), 0);
        chk("post_rst_no_rd", got_rd.size(), 0);
        issue_ar(OFS + 32'h60, 8'd3, 3'd3, 2'b01);
        wait_beats(4);
        model(OFS + 32'h60, 8'd3, 3'd3, 2'b01);
        cmp_model();

        rnd_mode = 1'b1;
        for (int n = 0; n < 60; n++) begin
            rsz = 3'($urandom % 5);
            rb  = 2'($urandom % 4);
            case ($urandom % 6)
                0:       rl = 8'd0;
                1:       rl = 8'd1;
                2:       rl = 8'd3;
                3:       rl = 8'd7;
                4:       rl = 8'd15;
                default: rl = 8'($urandom % 8);
            endcase
            if (RANGE_EN)
                ra = BASE - 32'h10 + ($urandom % 32'h120);
            else if ($urandom % 4 == 0)
                ra = 32'hFFFF_FFC0 + ($urandom % 64);
            else
                ra = $urandom;
            repeat ($urandom % 3) @(posedge clk);
            issue_ar(ra, rl, rsz, rb);
            wait_beats(int'(rl) + 1);
            model(ra, rl, rsz, rb);
            cmp_model();
        end
        rnd_mode = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
